// File: rtl/fetch_pc_ctrl_if.sv
// Fetch PC control bundle: pipeline-side redirect requests and PC outputs.
// The PC_RAS_EN macro adds the return-address-stack signals.
interface fetch_pc_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                F_Enable;
  logic                D_Br_Taken;
  logic [PC_WIDTH-1:0] D_Br_Target;
  logic                D_Jump;
  logic [PC_WIDTH-1:0] D_Jump_Target;
  logic                M_Exc_Req;
  logic                M_Eret_Req;
  logic [PC_WIDTH-1:0] M_Epc;
  logic [PC_WIDTH-1:0] F_PC;
  logic [PC_WIDTH-1:0] F_PC_Plus;
  logic                F_Redirected;
  logic                F_Misaligned;
  logic                F_Pending;
`ifdef PC_RAS_EN
  logic                D_Call;
  logic                D_Ret;
  logic [PC_WIDTH-1:0] F_Ras_Top;
  logic                F_Ras_Empty;
`endif

  modport master (
`ifdef PC_RAS_EN
    output D_Call,
    output D_Ret,
    input  F_Ras_Top,
    input  F_Ras_Empty,
`endif
    output F_Enable,
    output D_Br_Taken,
    output D_Br_Target,
    output D_Jump,
    output D_Jump_Target,
    output M_Exc_Req,
    output M_Eret_Req,
    output M_Epc,
    input  F_PC,
    input  F_PC_Plus,
    input  F_Redirected,
    input  F_Misaligned,
    input  F_Pending
  );

  modport slave (
`ifdef PC_RAS_EN
    input  D_Call,
    input  D_Ret,
    output F_Ras_Top,
    output F_Ras_Empty,
`endif
    input  F_Enable,
    input  D_Br_Taken,
    input  D_Br_Target,
    input  D_Jump,
    input  D_Jump_Target,
    input  M_Exc_Req,
    input  M_Eret_Req,
    input  M_Epc,
    output F_PC,
    output F_PC_Plus,
    output F_Redirected,
    output F_Misaligned,
    output F_Pending
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC with next-PC arbitration and stall-time redirect buffer.
// Optional return-address stack enabled by defining PC_RAS_EN.
module fetch_pc_ctrl #(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_3000,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = 32'h0000_4180,
  parameter int                  INSTR_BYTES = 4,
  parameter int                  RAS_DEPTH   = 4
) (
  input logic          Clk,
  input logic          Reset,
  fetch_pc_ctrl_if.slave bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [PC_WIDTH-1:0] INC =
    PC_WIDTH'(INSTR_BYTES);

  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic                redir_q, redir_d;
  logic                new_redir;
  logic [PC_WIDTH-1:0] new_tgt;

  // Exceptions are handled separately: they bypass the stall entirely.
  always_comb begin
    new_redir = bus.M_Eret_Req | bus.D_Br_Taken | bus.D_Jump;
    if (bus.M_Eret_Req)
      new_tgt = bus.M_Epc;
    else if (bus.D_Br_Taken)
      new_tgt = bus.D_Br_Target;
    else
      new_tgt = bus.D_Jump_Target;
  end

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    state_d = state_q;
    redir_d = 1'b0;
    if (bus.M_Exc_Req) begin
      pc_d    = EXC_VECTOR;
      state_d = S_RUN;
      redir_d = 1'b1;
    end else if (bus.F_Enable) begin
      state_d = S_RUN;
      if (new_redir) begin
        pc_d    = new_tgt;
        redir_d = 1'b1;
      end else if (state_q == S_HOLD) begin
        pc_d    = pend_q;
        redir_d = 1'b1;
      end else begin
        pc_d = pc_q + INC;
      end
    end else if (new_redir) begin
      // Younger redirect wins while stalled, regardless of source.
      pend_d  = new_tgt;
      state_d = S_HOLD;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
    end
  end

  assign bus.F_PC         = pc_q;
  assign bus.F_PC_Plus    = pc_q + INC;
  assign bus.F_Redirected = redir_q;
  assign bus.F_Misaligned = |pc_q[1:0];
  assign bus.F_Pending    = (state_q == S_HOLD);

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ?
    $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PMAX =
    PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CMAX =
    CW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       ptr_nxt, ptr_prv;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_en;
  logic [PW-1:0]       wr_idx;
  logic [PC_WIDTH-1:0] push_val;

  assign ptr_nxt  = (ptr_q == PMAX) ?
    '0 : ptr_q + PW'(1);
  assign ptr_prv  = (ptr_q == '0) ?
    PMAX : ptr_q - PW'(1);
  // Return lands past the delay slot.
  assign push_val = pc_q + INC + INC;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (bus.F_Enable) begin
      if (bus.D_Call && bus.D_Ret &&
          cnt_q != '0) begin
        wr_en = 1'b1;
      end else if (bus.D_Call) begin
        wr_en  = 1'b1;
        wr_idx = ptr_nxt;
        ptr_d  = ptr_nxt;
        if (cnt_q != CMAX)
          cnt_d = cnt_q + CW'(1);
      end else if (bus.D_Ret &&
                   cnt_q != '0) begin
        ptr_d = ptr_prv;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en)
      ras_q[wr_idx] <= push_val;
  end

  assign bus.F_Ras_Empty = (cnt_q == '0);
  assign bus.F_Ras_Top   = (cnt_q == '0) ?
    '0 : ras_q[ptr_q];
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed plan plus random traffic.
// RAS checks are compiled in when PC_RAS_EN is defined.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam int          DEPTH  = 4;

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic        pend;
    logic [31:0] top;
    logic        empty;
  } exp_t;

  logic Clk;
  logic Reset;

  fetch_pc_ctrl_if #(.PC_WIDTH(32)) bus ();

  fetch_pc_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  exp_t        sb [$];
  logic [31:0] m_pc;
  logic [31:0] m_pend [$];
  logic        m_redir;
  logic [31:0] m_ras [$];
  int          vectors = 0;
  int          errs    = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, want %h",
               nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_redir = 1'b0;
    m_pend.delete();
    m_ras.delete();
  endtask

  task automatic step(
    input bit en, input bit exc,
    input bit eret, input logic [31:0] epc,
    input bit br, input logic [31:0] brt,
    input bit jmp, input logic [31:0] jt,
    input bit call, input bit ret);
    bit          nw;
    logic [31:0] tgt;
    exp_t        e;
    bus.F_Enable      = en;
    bus.M_Exc_Req     = exc;
    bus.M_Eret_Req    = eret;
    bus.M_Epc         = epc;
    bus.D_Br_Taken    = br;
    bus.D_Br_Target   = brt;
    bus.D_Jump        = jmp;
    bus.D_Jump_Target = jt;
`ifdef PC_RAS_EN
    bus.D_Call = call;
    bus.D_Ret  = ret;
    if (en) begin
      if (call && ret && m_ras.size() > 0)
        m_ras[m_ras.size()-1] = m_pc + 8;
      else if (call) begin
        if (m_ras.size() == DEPTH)
          void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 8);
      end else if (ret && m_ras.size() > 0)
        void'(m_ras.pop_back());
    end
`endif
    nw  = eret | br | jmp;
    tgt = eret ? epc : (br ? brt : jt);
    if (exc) begin
      m_pc    = EXC_PC;
      m_redir = 1'b1;
      m_pend.delete();
    end else if (en) begin
      if (nw) begin
        m_pc    = tgt;
        m_redir = 1'b1;
      end else if (m_pend.size() > 0) begin
        m_pc    = m_pend[0];
        m_redir = 1'b1;
      end else begin
        m_pc    = m_pc + 4;
        m_redir = 1'b0;
      end
      m_pend.delete();
    end else begin
      m_redir = 1'b0;
      if (nw) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
    end
    e.pc    = m_pc;
    e.redir = m_redir;
    e.pend  = (m_pend.size() > 0);
    e.empty = (m_ras.size() == 0);
    e.top   = e.empty ? 32'h0 :
              m_ras[m_ras.size()-1];
    sb.push_back(e);
  endtask

  task automatic tick(
    input bit en, input bit exc,
    input bit eret, input logic [31:0] epc,
    input bit br, input logic [31:0] brt,
    input bit jmp, input logic [31:0] jt,
    input bit call, input bit ret);
    step(en, exc, eret, epc, br, brt,
         jmp, jt, call, ret);
    @(negedge Clk);
  endtask

  task automatic idle(input bit en);
    tick(en, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rtgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 7) != 0)
      v[1:0] = 2'b00;
    return v;
  endfunction

  exp_t me;
  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("F_PC", bus.F_PC, me.pc);
      chk("F_PC_Plus", bus.F_PC_Plus,
          me.pc + 32'd4);
      chk("F_Redirected",
          {31'b0, bus.F_Redirected},
          {31'b0, me.redir});
      chk("F_Pending",
          {31'b0, bus.F_Pending},
          {31'b0, me.pend});
      chk("F_Misaligned",
          {31'b0, bus.F_Misaligned},
          {31'b0, |me.pc[1:0]});
`ifdef PC_RAS_EN
      chk("F_Ras_Top", bus.F_Ras_Top, me.top);
      chk("F_Ras_Empty",
          {31'b0, bus.F_Ras_Empty},
          {31'b0, me.empty});
`endif
    end
  end

  initial begin
    Reset = 1'b1;
    bus.F_Enable      = 1'b0;
    bus.M_Exc_Req     = 1'b0;
    bus.M_Eret_Req    = 1'b0;
    bus.M_Epc         = '0;
    bus.D_Br_Taken    = 1'b0;
    bus.D_Br_Target   = '0;
    bus.D_Jump        = 1'b0;
    bus.D_Jump_Target = '0;
`ifdef PC_RAS_EN
    bus.D_Call = 1'b0;
    bus.D_Ret  = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge Clk);
    chk("rst F_PC", bus.F_PC, RST_PC);
    chk("rst F_Redirected",
        {31'b0, bus.F_Redirected}, 32'h0);
    chk("rst F_Pending",
        {31'b0, bus.F_Pending}, 32'h0);
    Reset = 1'b0;

    repeat (3) idle(1);
    tick(1, 0, 0, 0, 1, 32'h3100, 0, 0, 0, 0);
    idle(1);

    tick(0, 0, 0, 0, 0, 0, 1, 32'h3200, 0, 0);
    idle(0);
    idle(0);
    idle(1);
    idle(1);

    tick(0, 0, 0, 0, 0, 0, 1, 32'h3200, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);

    tick(1, 0, 1, 32'h3010, 1, 32'h3100,
         0, 0, 0, 0);
    idle(1);

    tick(0, 0, 0, 0, 1, 32'h5000, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 32'h6000, 0, 0);
    idle(1);

    tick(1, 0, 0, 0, 0, 0, 1,
         32'hFFFF_FFFC, 0, 0);
    idle(1);
    idle(1);

    repeat (5) tick(1, 0, 0, 0, 0, 0,
                    0, 0, 1, 0);
    repeat (5) tick(1, 0, 0, 0, 0, 0,
                    0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      bit br, jmp;
      br  = ($urandom_range(0, 5) == 0);
      jmp = !br && ($urandom_range(0, 5) == 0);
      tick($urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0,
           rtgt(), br, rtgt(), jmp, rtgt(),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0);
    end

    step(0, 0, 0, 0, 0, 0, 1, 32'h7000, 0, 0);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    chk("midrst F_PC", bus.F_PC, RST_PC);
    chk("midrst F_Pending",
        {31'b0, bus.F_Pending}, 32'h0);
    chk("midrst F_Redirected",
        {31'b0, bus.F_Redirected}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    idle(0);
    idle(1);
    idle(1);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge Clk);
    end
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d left, want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
